bist_signature_checker: RTL and testbench
=========================================

// Module: bist_signature_checker
// PURPOSE
//  Response side of the BIST handshake: consumes the controller's init/running/finish strobes
//  and the CUT response word, compacts responses into a MISR while running is high, and at
//  finish compares the signature and sample count against golden values. Drives pass_fail
//  back toward the controller and the top-level BIST result.
// PARAMETERS
//  WIDTH    16        CUT response and MISR width
//  POLY     16'h1021  MISR feedback polynomial (bit i set = tap into bit i)
//  SEED     16'hFFFF  MISR value loaded on init
//  GOLDEN   16'h0000  expected final signature (set per group at integration)
//  NSAMPLE  651       expected running-high cycles per session (NCLOCK+1)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-low; low clears all state
//  init       in   1      session start strobe from controller (1 cycle)
//  running    in   1      compact cut_resp this cycle
//  finish     in   1      session end strobe from controller (1 cycle)
//  cut_resp   in   WIDTH  CUT response word, sampled when running=1
//  signature  out  WIDTH  current MISR contents
//  sig_valid  out  1      result valid; held until next init or reset
//  pass_fail  out  1      1 = pass; meaningful only when sig_valid=1
//  proto_err  out  1      strobe-ordering violation seen in this session
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE, misr=SEED, count=0, sig_valid=0, pass_fail=0, proto_err=0.
//  States: IDLE -> ARMED (init) -> COMPACT (first running) -> CHECK (finish) -> DONE.
//  init in any state: misr<=SEED, count<=0, sig_valid/pass_fail/proto_err<=0, state<=ARMED.
//   init has priority over running/finish in the same cycle.
//  MISR step (ARMED/COMPACT, running=1): misr <= (misr<<1) ^ (misr[WIDTH-1] ? POLY : 0) ^ cut_resp;
//   count <= count+1, saturating at NSAMPLE+1; count width $clog2(NSAMPLE+2).
//  running=0 in COMPACT: misr and count hold (gaps allowed).
//  finish in ARMED/COMPACT -> CHECK; a running sample in the same cycle is still compacted.
//  CHECK (1 cycle): pass_fail <= (misr==GOLDEN) & (count==NSAMPLE) & !proto_err;
//   sig_valid <= 1; state<=DONE. Latency: finish at cycle t -> sig_valid=1 at t+2.
//  DONE: outputs held; running ignored (misr unchanged); only init or reset leaves.
//  Protocol errors (set proto_err=1, sig_valid=1, pass_fail=0, state<=DONE next cycle):
//   finish or running in IDLE; running or finish while in DONE is ignored, not an error.
//  signature is combinational from misr register; no other output is combinational.
// STRUCTURE
//  bist_pkg: state enum (IDLE, ARMED, COMPACT, CHECK, DONE), default POLY/SEED, WIDTH.
//  Sub-module bist_misr (WIDTH, POLY, SEED): load, enable, data_in -> misr; checker
//   FSM, sample counter and compare stay in this module.
// TESTING
//  T1 reset=0 mid-sim with random inputs -> all outputs 0, signature=16'hFFFF immediately.
//  T2 init, 651 running cycles cut_resp=16'h0000, finish; GOLDEN = model value
//     -> sig_valid=1 exactly 2 cycles after finish, pass_fail=1, proto_err=0.
//  T3 as T2 with cut_resp=16'h0001 on sample 300 -> signature != GOLDEN, pass_fail=0.
//  T4 as T2 with 650 running cycles (one gap cycle) -> count=650, pass_fail=0.
//  T5 finish with no prior init after reset -> proto_err=1, sig_valid=1, pass_fail=0;
//     subsequent init clears all three to 0.
//  T6 reset=0 during COMPACT (sample 100), release, finish -> proto_err=1, pass_fail=0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST response checker.
package bist_pkg;

  localparam int          WIDTH_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COMPACT = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: load has priority over a compaction step.
module bist_misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h1021,
  parameter logic [WIDTH-1:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] misr
);

  logic [WIDTH-1:0] misr_q;
  logic [WIDTH-1:0] misr_d;

  always_comb begin
    misr_d = misr_q;
    if (load) begin
      misr_d = SEED;
    end else if (enable) begin
      misr_d = {misr_q[WIDTH-2:0], 1'b0}
             ^ (misr_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
             ^ data_in;
    end else begin
      misr_d = misr_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misr_q <= SEED;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign misr = misr_q;

endmodule

// File: rtl/bist_signature_checker.sv
// BIST response checker: compacts CUT responses while running, then grades
// signature and sample count against golden values when the session finishes.
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int               WIDTH   = WIDTH_DEF,
  parameter logic [WIDTH-1:0] POLY    = POLY_DEF,
  parameter logic [WIDTH-1:0] SEED    = SEED_DEF,
  parameter logic [WIDTH-1:0] GOLDEN  = 16'h0000,
  parameter int               NSAMPLE = 651
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             finish,
  input  logic [WIDTH-1:0] cut_resp,
  output logic [WIDTH-1:0] signature,
  output logic             sig_valid,
  output logic             pass_fail,
  output logic             proto_err
);

  localparam int             CW        = $clog2(NSAMPLE + 2);
  localparam logic [CW-1:0]  COUNT_EXP = CW'(NSAMPLE);
  // One past the expected count, so over-long sessions cannot wrap back to a match.
  localparam logic [CW-1:0]  COUNT_MAX = CW'(NSAMPLE + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sig_valid_q, sig_valid_d;
  logic            pass_fail_q, pass_fail_d;
  logic            proto_err_q, proto_err_d;
  logic            misr_load_s;
  logic            misr_en_s;
  logic [WIDTH-1:0] misr_s;

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk     (clk),
    .reset   (reset),
    .load    (misr_load_s),
    .enable  (misr_en_s),
    .data_in (cut_resp),
    .misr    (misr_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_q     <= {CW{1'b0}};
      sig_valid_q <= 1'b0;
      pass_fail_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sig_valid_q <= sig_valid_d;
      pass_fail_q <= pass_fail_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        IDLE:    state_d = (running || finish) ? DONE : IDLE;
        ARMED:   state_d = finish ? CHECK : (running ? COMPACT : ARMED);
        COMPACT: state_d = finish ? CHECK : COMPACT;
        CHECK:   state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    misr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    count_d     = count_q;
    sig_valid_d = sig_valid_q;
    pass_fail_d = pass_fail_q;
    proto_err_d = proto_err_q;
    if (init) begin
      misr_load_s = 1'b1;
      count_d     = {CW{1'b0}};
      sig_valid_d = 1'b0;
      pass_fail_d = 1'b0;
      proto_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Strobes with no session open are reported as a failed result.
          if (running || finish) begin
            proto_err_d = 1'b1;
            sig_valid_d = 1'b1;
            pass_fail_d = 1'b0;
          end else begin
            proto_err_d = proto_err_q;
          end
        end
        ARMED, COMPACT: begin
          if (running) begin
            misr_en_s = 1'b1;
            count_d   = (count_q == COUNT_MAX) ? count_q : count_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            misr_en_s = 1'b0;
          end
        end
        CHECK: begin
          sig_valid_d = 1'b1;
          pass_fail_d = (misr_s == GOLDEN) && (count_q == COUNT_EXP) && !proto_err_q;
        end
        DONE:    sig_valid_d = sig_valid_q;
        default: sig_valid_d = sig_valid_q;
      endcase
    end
  end

  assign signature = misr_s;
  assign sig_valid = sig_valid_q;
  assign pass_fail = pass_fail_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bist_signature_checker.sv
// Scoreboard bench for bist_signature_checker: expected results are queued when
// finish is driven and graded by a negedge monitor at their due cycle.
module tb_bist_signature_checker;

  localparam int NS = 651;

  function automatic logic [15:0] calc_golden(input int n);
    logic [15:0] m;
    m = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000);
    end
    return m;
  endfunction

  localparam logic [15:0] GOLD = calc_golden(NS);

  function automatic logic [15:0] model_step(input logic [15:0] m, input logic [15:0] d);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  logic        clk = 1'b0;
  logic        reset, init, running, finish;
  logic [15:0] cut_resp, signature;
  logic        sig_valid, pass_fail, proto_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    string       tag;
    logic [15:0] sig;
    logic        pf;
    logic        pe;
    int          due;
    bit          early;
  } exp_t;

  exp_t sb_q[$];

  bist_signature_checker #(
    .WIDTH   (16),
    .POLY    (16'h1021),
    .SEED    (16'hFFFF),
    .GOLDEN  (GOLD),
    .NSAMPLE (NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .running   (running),
    .finish    (finish),
    .cut_resp  (cut_resp),
    .signature (signature),
    .sig_valid (sig_valid),
    .pass_fail (pass_fail),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      if (e.early && cyc == e.due - 1) begin
        check_val({e.tag, "_early_valid"}, {31'd0, sig_valid}, 32'd0);
      end else if (cyc == e.due) begin
        check_val({e.tag, "_sig_valid"}, {31'd0, sig_valid}, 32'd1);
        check_val({e.tag, "_pass_fail"}, {31'd0, pass_fail}, {31'd0, e.pf});
        check_val({e.tag, "_proto_err"}, {31'd0, proto_err}, {31'd0, e.pe});
        check_val({e.tag, "_signature"}, {16'd0, signature}, {16'd0, e.sig});
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init = 1'b0; running = 1'b0; finish = 1'b0; cut_resp = 16'h0000;
  endtask

  task automatic push_exp(input string tag, input logic [15:0] sig, input logic pf,
                          input logic pe, input int lat);
    exp_t e;
    e.tag = tag; e.sig = sig; e.pf = pf; e.pe = pe;
    e.due = cyc + lat; e.early = (lat == 2);
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() != 0) begin
      check_val({tag, "_timeout"}, sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  // Full session: n_run samples, optional bad sample index and gap position.
  task automatic session(input string tag, input int n_run, input int bad_idx,
                         input int gap_at, output logic [15:0] m);
    init = 1'b1; tick(); init = 1'b0;
    m = 16'hFFFF;
    for (int i = 0; i < n_run; i++) begin
      if (i == gap_at) begin
        running = 1'b0; cut_resp = 16'h0000; tick();
      end
      running  = 1'b1;
      cut_resp = (i == bad_idx) ? 16'h0001 : 16'h0000;
      m = model_step(m, cut_resp);
      if (i == n_run - 1) begin
        finish = 1'b1;
        push_exp(tag, m, (m == GOLD) && (n_run == NS), 1'b0, 2);
      end
      tick();
    end
    idle_inputs();
    drain(tag);
  endtask

  initial begin
    logic [15:0] m;
    reset = 1'b0;
    idle_inputs();
    tick(); tick();
    check_val("rst_signature", {16'd0, signature}, 32'h0000FFFF);
    check_val("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    check_val("rst_pass_fail", {31'd0, pass_fail}, 32'd0);
    check_val("rst_proto_err", {31'd0, proto_err}, 32'd0);
    #2 reset = 1'b1;
    tick();

    // T2: clean session, last sample coincides with finish
    session("t2", NS, -1, -1, m);
    // DONE ignores running: signature and result stay put
    running = 1'b1; cut_resp = 16'hABCD;
    tick(); tick(); tick();
    idle_inputs();
    check_val("done_hold_sig", {16'd0, signature}, {16'd0, m});
    check_val("done_hold_valid", {31'd0, sig_valid}, 32'd1);
    check_val("done_hold_pass", {31'd0, pass_fail}, 32'd1);

    // T1: async reset mid-cycle with random inputs applied
    init = 1'($urandom); running = 1'($urandom); finish = 1'($urandom);
    cut_resp = 16'($urandom);
    #2 reset = 1'b0;
    #1;
    check_val("t1_signature", {16'd0, signature}, 32'h0000FFFF);
    check_val("t1_sig_valid", {31'd0, sig_valid}, 32'd0);
    check_val("t1_pass_fail", {31'd0, pass_fail}, 32'd0);
    check_val("t1_proto_err", {31'd0, proto_err}, 32'd0);
    idle_inputs();
    tick();
    #2 reset = 1'b1;
    tick();

    // T3: single corrupted sample
    session("t3", NS, 300, -1, m);
    check_val("t3_sig_differs", {31'd0, (signature != GOLD)}, 32'd1);

    // T4: one sample short with a gap cycle
    session("t4", NS - 1, -1, 325, m);
    check_val("t4_count", 32'(dut.count_q), 32'd650);

    // T5: finish straight out of reset, then init clears the result
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    tick();
    finish = 1'b1;
    push_exp("t5", 16'hFFFF, 1'b0, 1'b1, 1);
    tick();
    idle_inputs();
    drain("t5");
    init = 1'b1; tick(); init = 1'b0;
    check_val("t5_clr_valid", {31'd0, sig_valid}, 32'd0);
    check_val("t5_clr_pass", {31'd0, pass_fail}, 32'd0);
    check_val("t5_clr_perr", {31'd0, proto_err}, 32'd0);

    // T6: reset during compaction, then a stray finish
    for (int i = 0; i < 100; i++) begin
      running = 1'b1; cut_resp = 16'($urandom); tick();
    end
    #2 reset = 1'b0;
    #1;
    check_val("t6_rst_signature", {16'd0, signature}, 32'h0000FFFF);
    #1 reset = 1'b1;
    idle_inputs();
    tick();
    finish = 1'b1;
    push_exp("t6", 16'hFFFF, 1'b0, 1'b1, 1);
    tick();
    idle_inputs();
    drain("t6");

    // init wins over running and finish in the same cycle
    init = 1'b1; running = 1'b1; finish = 1'b1; cut_resp = 16'h1234;
    tick();
    idle_inputs();
    check_val("prio_signature", {16'd0, signature}, 32'h0000FFFF);
    check_val("prio_sig_valid", {31'd0, sig_valid}, 32'd0);
    check_val("prio_proto_err", {31'd0, proto_err}, 32'd0);
    finish = 1'b1;
    push_exp("prio_empty", 16'hFFFF, 1'b0, 1'b0, 2);
    tick();
    idle_inputs();
    drain("prio_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
